// File: rtl/dram_device.sv
// rtl/dram_device.sv - single-bank DRAM device model with tRCD checking and CAS-latency read pipeline
module dram_device #(
  parameter int ROW_BITS = 11,
  parameter int CAS_LAT  = 5,
  parameter int T_RCD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        prot_err
);

  localparam int AW = ROW_BITS + 10;
  localparam logic [7:0] RCD = 8'(T_RCD);

  typedef enum logic {CLOSED, OPEN} state_t;

  state_t              state, state_nx;
  logic [ROW_BITS-1:0] row;
  logic [7:0]          rcd_cnt, rcd_next;
  logic                rcd_ok;
  logic                cmd_act, cmd_pre, cmd_rd, cmd_wr;
  logic                do_act, do_rd, do_wr, err;
  logic [AW-1:0]       addr;
  logic [31:0]         mem [0:(1<<AW)-1];
  logic [CAS_LAT-1:0]  pipe_v;
  logic [31:0]         pipe_d [CAS_LAT];

  assign cmd_act = !DRAM_CSn && !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn == 4'hF);
  assign cmd_pre = !DRAM_CSn && !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn == 4'h0);
  assign cmd_rd  = !DRAM_CSn &&  DRAM_RASn && !DRAM_CASn && (DRAM_WEn == 4'hF);
  assign cmd_wr  = !DRAM_CSn &&  DRAM_RASn && !DRAM_CASn && (DRAM_WEn != 4'hF);
  assign addr    = {row, DRAM_A[9:0]};

  // The edge carrying a column command counts toward tRCD, so a command on
  // the T_RCD-th edge after ACT is the first legal one.
  assign rcd_next = (rcd_cnt == RCD) ? RCD : rcd_cnt + 8'd1;
  assign rcd_ok   = (rcd_next == RCD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLOSED;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLOSED: if (cmd_act) state_nx = OPEN;
      OPEN:   if (cmd_pre) state_nx = CLOSED;
      default: state_nx = CLOSED;
    endcase
  end

  always_comb begin
    do_act = cmd_act && (state == CLOSED);
    do_rd  = cmd_rd && (state == OPEN) && rcd_ok;
    do_wr  = cmd_wr && (state == OPEN) && rcd_ok;
    err    = (cmd_act && (state == OPEN)) ||
             ((cmd_rd || cmd_wr) && ((state == CLOSED) || !rcd_ok));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row      <= '0;
      rcd_cnt  <= '0;
      prot_err <= 1'b0;
    end else begin
      if (do_act) begin
        row     <= DRAM_A[ROW_BITS-1:0];
        rcd_cnt <= '0;
      end else if (state == OPEN) begin
        rcd_cnt <= rcd_next;
      end
      if (err) prot_err <= 1'b1;
    end
  end

  // Memory and read data carry no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++)
        if (!DRAM_WEn[i]) mem[addr][8*i +: 8] <= DRAM_D[8*i +: 8];
    end
    pipe_d[0] <= mem[addr];
    for (int i = 1; i < CAS_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v     <= '0;
      DRAM_valid <= 1'b0;
      DRAM_Q     <= '0;
    end else begin
      pipe_v[0] <= do_rd;
      for (int i = 1; i < CAS_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      DRAM_valid <= pipe_v[CAS_LAT-1];
      if (pipe_v[CAS_LAT-1]) DRAM_Q <= pipe_d[CAS_LAT-1];
    end
  end

endmodule

// File: doc/dram_device.md
DRAM_DEVICE -- requirements
Module: dram_device

Interface
REQ-001 SHALL have parameter ROW_BITS, default 11, meaning row-address width; storage depth is 2^(ROW_BITS+10) 32-bit words.
REQ-002 SHALL have parameter CAS_LAT, default 5, meaning cycles from the read-command edge to the DRAM_valid pulse; legal range 1..7.
REQ-003 SHALL have parameter T_RCD, default 4, meaning the minimum cycles from an activate edge to the first column command.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port DRAM_CSn, input, 1 bit: chip select, active low; when high, all commands are ignored.
REQ-007 SHALL have port DRAM_RASn, input, 1 bit: row strobe, active low.
REQ-008 SHALL have port DRAM_CASn, input, 1 bit: column strobe, active low.
REQ-009 SHALL have port DRAM_WEn, input, 4 bits: per-byte write enable, active low; bit i enables byte i.
REQ-010 SHALL have port DRAM_A, input, 11 bits: row address for activate and precharge; A[9:0] is the column for read and write.
REQ-011 SHALL have port DRAM_D, input, 32 bits: write data.
REQ-012 SHALL have port DRAM_Q, output, 32 bits: read data.
REQ-013 SHALL have port DRAM_valid, output, 1 bit: one-cycle pulse marking DRAM_Q valid.
REQ-014 SHALL have port prot_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-015 SHALL decode commands on rising clk edges only when CSn=0:
- ACT: RASn=0, CASn=1, WEn=F.
- PRE: RASn=0, CASn=1, WEn=0.
- RD: RASn=1, CASn=0, WEn=F.
- WR: RASn=1, CASn=0, WEn!=F.
- NOP: all other combinations.
REQ-016 SHALL implement a bank FSM with states CLOSED and OPEN:
- ACT in CLOSED latches row=A[ROW_BITS-1:0], moves to OPEN and clears the tRCD counter.
- PRE in OPEN moves to CLOSED.
- PRE in CLOSED is a legal no-op.
REQ-017 SHALL saturate the tRCD counter at T_RCD; a RD or WR is legal only when the counter equals T_RCD, i.e. at least T_RCD edges after ACT.
REQ-018 SHALL treat each of these as illegal, ignore the command and set prot_err: ACT while OPEN; RD or WR while CLOSED; RD or WR before tRCD is met.
REQ-019 SHALL form word address {row, A[9:0]} for RD and WR; A[10] is ignored.
REQ-020 SHALL perform WR in the command cycle, updating only the bytes with WEn[i]=0.
REQ-021 SHALL sample memory for RD at the command edge; a WR in an earlier cycle is visible, and same-edge RD/WR cannot occur.
REQ-022 SHALL carry RD results through a CAS_LAT-deep valid/data pipeline:
- DRAM_valid is high exactly CAS_LAT cycles after the RD edge, for one cycle.
- Back-to-back RDs on consecutive cycles return on consecutive cycles in order.
REQ-023 SHALL update DRAM_Q only on a valid pulse and hold it otherwise.
REQ-024 SHALL not cancel in-flight reads on PRE.
REQ-025 SHALL clear prot_err only on reset.

Reset
REQ-026 SHALL, while rst=0, force: FSM=CLOSED, row=0, tRCD counter=0, pipeline valids=0, DRAM_Q=0, DRAM_valid=0, prot_err=0.
REQ-027 SHALL not initialise or alter memory contents on reset.
REQ-028 SHALL discard in-flight reads on reset mid-operation; no valid pulse is produced after rst rises for reads issued before it.

Verification
REQ-029 Scenario: ACT row 3; WR col 5, D=A5A5_1234, WEn=0 on the 4th edge after ACT; RD col 5 -> DRAM_valid exactly 5 cycles after RD, Q=A5A5_1234, prot_err=0.
REQ-030 Scenario: prefill word 0xDEADBEEF; WR with WEn=4'b1010, D=0x11223344; then RD -> Q=0xDE22BE44.
REQ-031 Scenario: ACT; RD cols 0,1,2 on consecutive cycles -> three consecutive valid pulses with data in order; PRE issued during flight does not drop them.
REQ-032 Scenario: RD 2 cycles after ACT -> no valid pulse, prot_err=1; a following legal RD still returns data; prot_err stays 1.
REQ-033 Scenario: ACT while OPEN, and RD after PRE -> each ignored, prot_err=1, row unchanged.
REQ-034 Scenario: rst low 2 cycles after a RD -> no valid pulse afterwards, Q=0, prot_err=0, memory data retained for a later RD.
